// File: rtl/in_service_ctrl.sv
// in_service_ctrl
//   Back end of the 8259 priority resolver. Raises INT to the CPU from the
//   resolver's request, runs the two-pulse INTA acknowledge, holds the
//   In-Service Register and executes OCW2 EOI / rotation commands.
//
// Ports
//   clk, rst_n (sync, active-low), init (ICW1 write, same effect as reset)
//   int_flag, priority_id       resolver request and winning level
//   inta                        one-cycle strobe per INTA pulse
//   vector_base                 T7..T3 from ICW2
//   aeoi_mode                   AEOI bit from ICW4
//   ocw2_valid/cmd/level        OCW2 write {R,SL,EOI} and L2..L0
//   int_out                     INT to the CPU
//   irr_clear                   one-hot clear of the acknowledged IRR bit
//   is_status                   ISR contents
//   last_serviced               lowest-priority level when rotating
//   rotating_priority           rotation mode
//   vector_out, vector_valid    {vector_base, level}, valid for one cycle
//
// Build option
//   IN_SERVICE_CTRL_AEOI_EN : enables AEOI (aeoi_mode) and the AEOI-rotate
//   flag (OCW2 100/000). Without it the ISR is cleared only by EOI commands.
//
// state | meaning
// IDLE  | waiting for an interrupt request
// PEND  | int_out is high, waiting for INTA #1
// ACK1  | INTA #1 taken, waiting for INTA #2

module in_service_ctrl #(
   parameter int VECTOR_W = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                init,
   input  logic                int_flag,
   input  logic [2:0]          priority_id,
   input  logic                inta,
   input  logic [VECTOR_W-1:0] vector_base,
   input  logic                aeoi_mode,
   input  logic                ocw2_valid,
   input  logic [2:0]          ocw2_cmd,
   input  logic [2:0]          ocw2_level,
   output logic                int_out,
   output logic [7:0]          irr_clear,
   output logic [7:0]          is_status,
   output logic [2:0]          last_serviced,
   output logic                rotating_priority,
   output logic [7:0]          vector_out,
   output logic                vector_valid
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PEND = 2'd1,
      S_ACK1 = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] ack_level_q, ack_level_d;
   logic       int_out_d, vector_valid_d, rot_d;
   logic [7:0] irr_clear_d, isr_d, vector_out_d;
   logic [7:0] isr_set, isr_clr;
   logic [2:0] last_d;
   logic       aeoi_active;

   logic       hp_found;
   logic [2:0] hp_level, scan_base, scan_idx;

`ifdef IN_SERVICE_CTRL_AEOI_EN
   logic aeoi_rot_q, aeoi_rot_d;
   assign aeoi_active = aeoi_mode;
`else
   logic unused_aeoi_mode;
   assign unused_aeoi_mode = aeoi_mode;
   assign aeoi_active      = 1'b0;
`endif

   // Highest-priority in-service level. Fully nested mode is the rotating
   // scan started just after level 7, i.e. lowest index first.
   always_comb begin
      hp_found  = 1'b0;
      hp_level  = 3'd0;
      scan_idx  = 3'd0;
      scan_base = rotating_priority ? last_serviced : 3'd7;
      for (int i = 1; i <= 8; i++) begin
         scan_idx = scan_base + 3'(i);
         if (!hp_found && is_status[scan_idx]) begin
            hp_found = 1'b1;
            hp_level = scan_idx;
         end
      end
   end

   always_comb begin
      state_d        = state_q;
      ack_level_d    = ack_level_q;
      int_out_d      = int_out;
      irr_clear_d    = 8'h00;
      vector_out_d   = vector_out;
      vector_valid_d = 1'b0;
      last_d         = last_serviced;
      rot_d          = rotating_priority;
      isr_set        = 8'h00;
      isr_clr        = 8'h00;
`ifdef IN_SERVICE_CTRL_AEOI_EN
      aeoi_rot_d     = aeoi_rot_q;
`endif

      unique case (state_q)
         S_IDLE: begin
            if (inta) begin
               // spurious acknowledge: answer with level 7, touch nothing
               ack_level_d = 3'd7;
               state_d     = S_ACK1;
            end else if (int_flag) begin
               int_out_d = 1'b1;
               state_d   = S_PEND;
            end
         end
         S_PEND: begin
            // int_flag dropping here is ignored: INT is never retracted
            if (inta) begin
               ack_level_d = priority_id;
               isr_set     = 8'h01 << priority_id;
               irr_clear_d = 8'h01 << priority_id;
               int_out_d   = 1'b0;
               state_d     = S_ACK1;
            end
         end
         S_ACK1: begin
            if (inta) begin
               vector_out_d   = 8'({vector_base, ack_level_q});
               vector_valid_d = 1'b1;
               state_d        = S_IDLE;
               if (aeoi_active) begin
                  isr_clr = 8'h01 << ack_level_q;
               end
`ifdef IN_SERVICE_CTRL_AEOI_EN
               if (aeoi_active && aeoi_rot_q) begin
                  last_d = ack_level_q;
               end
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (ocw2_valid) begin
         unique case (ocw2_cmd)
            3'b001: begin
               if (hp_found) isr_clr = isr_clr | (8'h01 << hp_level);
            end
            3'b011: isr_clr = isr_clr | (8'h01 << ocw2_level);
            3'b101: begin
               if (hp_found) begin
                  isr_clr = isr_clr | (8'h01 << hp_level);
                  last_d  = hp_level;
                  rot_d   = 1'b1;
               end
            end
            3'b111: begin
               isr_clr = isr_clr | (8'h01 << ocw2_level);
               last_d  = ocw2_level;
               rot_d   = 1'b1;
            end
            3'b110: begin
               last_d = ocw2_level;
               rot_d  = 1'b1;
            end
            3'b100: begin
`ifdef IN_SERVICE_CTRL_AEOI_EN
               aeoi_rot_d = 1'b1;
`endif
            end
            3'b000: begin
`ifdef IN_SERVICE_CTRL_AEOI_EN
               aeoi_rot_d = 1'b0;
`endif
            end
            default: ;
         endcase
      end

      // a bit being set by INTA #1 wins over an EOI aimed at it
      isr_d = (is_status & ~isr_clr) | isr_set;
   end

   always_ff @(posedge clk) begin
      if (!rst_n || init) begin
         state_q           <= S_IDLE;
         ack_level_q       <= 3'd0;
         int_out           <= 1'b0;
         irr_clear         <= 8'h00;
         is_status         <= 8'h00;
         last_serviced     <= 3'b111;
         rotating_priority <= 1'b0;
         vector_out        <= 8'h00;
         vector_valid      <= 1'b0;
      end else begin
         state_q           <= state_d;
         ack_level_q       <= ack_level_d;
         int_out           <= int_out_d;
         irr_clear         <= irr_clear_d;
         is_status         <= isr_d;
         last_serviced     <= last_d;
         rotating_priority <= rot_d;
         vector_out        <= vector_out_d;
         vector_valid      <= vector_valid_d;
      end
   end

`ifdef IN_SERVICE_CTRL_AEOI_EN
   always_ff @(posedge clk) begin
      if (!rst_n || init) aeoi_rot_q <= 1'b0;
      else                aeoi_rot_q <= aeoi_rot_d;
   end
`endif

endmodule

// File: tb/tb_in_service_ctrl.sv
module tb_in_service_ctrl;

   logic       clk = 1'b0;
   logic       rst_n, init, int_flag, inta, aeoi_mode, ocw2_valid;
   logic [2:0] priority_id, ocw2_cmd, ocw2_level;
   logic [4:0] vector_base;
   logic       int_out, rotating_priority, vector_valid;
   logic [7:0] irr_clear, is_status, vector_out;
   logic [2:0] last_serviced;

   int n_checks = 0;
   int n_fail   = 0;

   in_service_ctrl #(.VECTOR_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .init(init), .int_flag(int_flag),
      .priority_id(priority_id), .inta(inta), .vector_base(vector_base),
      .aeoi_mode(aeoi_mode), .ocw2_valid(ocw2_valid), .ocw2_cmd(ocw2_cmd),
      .ocw2_level(ocw2_level), .int_out(int_out), .irr_clear(irr_clear),
      .is_status(is_status), .last_serviced(last_serviced),
      .rotating_priority(rotating_priority), .vector_out(vector_out),
      .vector_valid(vector_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Tracks the acknowledge protocol as "how many INTA pulses has the
   // current request received", and the ISR as a plain bit set.
   localparam int P_WAIT = 0, P_RAISED = 1, P_FIRST = 2;
   int         m_phase;
   int         m_ack;
   logic       m_int, m_rot, m_vv, m_aeoi_rot;
   logic [7:0] m_irr, m_isr, m_vec, m_set, m_clr;
   logic [2:0] m_last;
   int         m_hp;

   function automatic int highest(input logic [7:0] v, input logic r, input logic [2:0] l);
      int start;
      start = r ? (int'(l) + 1) % 8 : 0;
      for (int k = 0; k < 8; k++)
         if (v[(start + k) % 8]) return (start + k) % 8;
      return -1;
   endfunction

   function automatic logic aeoi_on(input logic mode);
`ifdef IN_SERVICE_CTRL_AEOI_EN
      return mode;
`else
      return 1'b0;
`endif
   endfunction

   always @(posedge clk) begin
      if (!rst_n || init) begin
         m_phase = P_WAIT; m_ack = 0; m_int = 0; m_irr = 0; m_isr = 0;
         m_last = 3'd7; m_rot = 0; m_vec = 0; m_vv = 0; m_aeoi_rot = 0;
      end else begin
         m_set = 0; m_clr = 0; m_irr = 0; m_vv = 0;
         m_hp  = highest(m_isr, m_rot, m_last);
         if (m_phase == P_WAIT) begin
            if (inta) begin m_ack = 7; m_phase = P_FIRST; end
            else if (int_flag) begin m_int = 1; m_phase = P_RAISED; end
         end else if (m_phase == P_RAISED) begin
            if (inta) begin
               m_ack = int'(priority_id);
               m_set[m_ack] = 1'b1;
               m_irr = m_set;
               m_int = 0;
               m_phase = P_FIRST;
            end
         end else if (inta) begin
            m_vec = {vector_base, 3'(m_ack)};
            m_vv  = 1;
            m_phase = P_WAIT;
            if (aeoi_on(aeoi_mode)) begin
               m_clr[m_ack] = 1'b1;
               if (m_aeoi_rot) m_last = 3'(m_ack);
            end
         end
         if (ocw2_valid) begin
            case (ocw2_cmd)
               3'b001: if (m_hp >= 0) m_clr[m_hp] = 1'b1;
               3'b011: m_clr[ocw2_level] = 1'b1;
               3'b101: if (m_hp >= 0) begin
                  m_clr[m_hp] = 1'b1; m_last = 3'(m_hp); m_rot = 1;
               end
               3'b111: begin m_clr[ocw2_level] = 1'b1; m_last = ocw2_level; m_rot = 1; end
               3'b110: begin m_last = ocw2_level; m_rot = 1; end
               3'b100: if (aeoi_on(1'b1)) m_aeoi_rot = 1;
               3'b000: if (aeoi_on(1'b1)) m_aeoi_rot = 0;
               default: ;
            endcase
         end
         m_isr = (m_isr & ~m_clr) | m_set;
      end
   end

   // every-cycle comparison against the model
   always @(posedge clk) begin
      #1;
      chk("int_out", int_out, m_int);
      chk("irr_clear", irr_clear, m_irr);
      chk("is_status", is_status, m_isr);
      chk("last_serviced", last_serviced, m_last);
      chk("rotating_priority", rotating_priority, m_rot);
      chk("vector_valid", vector_valid, m_vv);
      if (m_vv) chk("vector_out", vector_out, m_vec);
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic pulse_inta();
      inta = 1; tick(); inta = 0;
   endtask

   task automatic ocw2(input logic [2:0] cmd, input logic [2:0] lvl);
      ocw2_valid = 1; ocw2_cmd = cmd; ocw2_level = lvl; tick(); ocw2_valid = 0;
   endtask

   task automatic request(input logic [2:0] pid);
      int_flag = 1; priority_id = pid; tick(); int_flag = 0;
   endtask

   task automatic ack_full();
      pulse_inta(); tick(); pulse_inta();
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " int_out"}, int_out, 1'b0);
      chk({tag, " irr_clear"}, irr_clear, 8'h00);
      chk({tag, " is_status"}, is_status, 8'h00);
      chk({tag, " last_serviced"}, last_serviced, 3'd7);
      chk({tag, " rotating_priority"}, rotating_priority, 1'b0);
      chk({tag, " vector_out"}, vector_out, 8'h00);
      chk({tag, " vector_valid"}, vector_valid, 1'b0);
   endtask

   initial begin
      rst_n = 0; init = 0; int_flag = 0; inta = 0; aeoi_mode = 0;
      ocw2_valid = 0; priority_id = 0; ocw2_cmd = 0; ocw2_level = 0;
      vector_base = 5'h08;
      tick(); tick();
      chk_reset_vals("reset");
      rst_n = 1; tick();

      // fully nested request at level 3
      request(3'd3);
      chk("req int_out", int_out, 1'b1);
      tick();
      chk("no retraction", int_out, 1'b1);
      pulse_inta();
      chk("inta1 irr_clear", irr_clear, 8'h08);
      chk("inta1 is_status", is_status, 8'h08);
      chk("inta1 int_out", int_out, 1'b0);
      chk("model isr pin", m_isr, 8'h08);
      tick();
      chk("irr_clear one cycle", irr_clear, 8'h00);
      pulse_inta();
      chk("inta2 valid", vector_valid, 1'b1);
      chk("inta2 vector", vector_out, 8'h43);
      chk("model vector pin", m_vec, 8'h43);
      tick();
      chk("valid one cycle", vector_valid, 1'b0);

      // non-specific then specific EOI, fully nested
      request(3'd1); ack_full();
      chk("nested isr", is_status, 8'h0A);
      ocw2(3'b001, 3'd0);
      chk("ns eoi", is_status, 8'h08);
      ocw2(3'b011, 3'd3);
      chk("spec eoi", is_status, 8'h00);

      // rotate on non-specific EOI
      ocw2(3'b110, 3'd3);
      chk("set prio last", last_serviced, 3'd3);
      chk("set prio rot", rotating_priority, 1'b1);
      request(3'd1); ack_full(); tick();
      request(3'd5); ack_full();
      chk("rot isr", is_status, 8'h22);
      ocw2(3'b101, 3'd0);
      chk("rot eoi isr", is_status, 8'h02);
      chk("rot eoi last", last_serviced, 3'd5);
      chk("model last pin", m_last, 3'd5);
      ocw2(3'b101, 3'd0);
      chk("rot wrap isr", is_status, 8'h00);
      chk("rot wrap last", last_serviced, 3'd1);
      ocw2(3'b101, 3'd0);
      chk("rot empty last", last_serviced, 3'd1);
      chk("rot empty isr", is_status, 8'h00);

      // spurious INTA
      pulse_inta();
      chk("spur irr_clear", irr_clear, 8'h00);
      chk("spur isr", is_status, 8'h00);
      tick(); pulse_inta();
      chk("spur valid", vector_valid, 1'b1);
      chk("spur vector", vector_out, 8'h47);

      // EOI colliding with INTA #1 on the same bit: set wins
      request(3'd2);
      inta = 1; ocw2_valid = 1; ocw2_cmd = 3'b011; ocw2_level = 3'd2;
      tick(); inta = 0; ocw2_valid = 0;
      chk("collide isr", is_status, 8'h04);
      tick(); pulse_inta();
      // non-specific EOI with INTA #1: selects from the old ISR
      request(3'd0);
      inta = 1; ocw2_valid = 1; ocw2_cmd = 3'b001; ocw2_level = 3'd0;
      tick(); inta = 0; ocw2_valid = 0;
      chk("ns collide isr", is_status, 8'h01);
      tick(); pulse_inta();
      ocw2(3'b011, 3'd0);

      // AEOI with rotate flag
      aeoi_mode = 1;
      ocw2(3'b100, 3'd0);
      request(3'd6); pulse_inta();
      chk("aeoi inta1 isr", is_status, 8'h40);
      tick(); pulse_inta();
`ifdef IN_SERVICE_CTRL_AEOI_EN
      chk("aeoi isr", is_status, 8'h00);
      chk("aeoi last", last_serviced, 3'd6);
`else
      chk("no aeoi isr", is_status, 8'h40);
      chk("no aeoi last", last_serviced, 3'd1);
      ocw2(3'b011, 3'd6);
`endif
      aeoi_mode = 0;

      // reset in the middle of the acknowledge
      request(3'd4); pulse_inta();
      chk("mid isr", is_status, 8'h10);
      rst_n = 0; tick(); rst_n = 1;
      chk_reset_vals("mid reset");
      pulse_inta();
      chk("post reset no vector", vector_valid, 1'b0);
      tick();
      chk("post reset no vector 2", vector_valid, 1'b0);
      init = 1; tick(); init = 0;
      request(3'd2); ack_full();
      chk("new req vector", vector_out, 8'h42);
      chk("new req isr", is_status, 8'h04);
      init = 1; tick(); init = 0;
      chk_reset_vals("init");
      tick(); tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/in_service_ctrl.md
# in_service_ctrl

Downstream stage of the 8259 priority resolver. It turns the resolver's `INTFLAG`/`PriorityID` into the CPU interrupt line and runs the two-pulse INTA acknowledge sequence. It holds the In-Service Register and executes OCW2 end-of-interrupt and rotation commands. Its `is_status`, `last_serviced` and `rotating_priority` outputs feed back into the resolver; `irr_clear` feeds the IRR.

## Interface
- `VECTOR_W`, default 5: width of the vector base (T7..T3).
- `clk`  in  1: system clock, rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `init`  in  1: one-cycle pulse on an ICW1 write; same effect as reset.
- `int_flag`  in  1: resolver `INTFLAG`.
- `priority_id`  in  3: resolver `PriorityID`.
- `inta`  in  1: one-cycle strobe per INTA pulse, already synchronised.
- `vector_base`  in  VECTOR_W: T7..T3 from ICW2.
- `aeoi_mode`  in  1: AEOI bit from ICW4.
- `ocw2_valid`  in  1: one-cycle OCW2 write strobe.
- `ocw2_cmd`  in  3: OCW2 {R,SL,EOI}.
- `ocw2_level`  in  3: OCW2 L2..L0.
- `int_out`  out  1: INT to the CPU.
- `irr_clear`  out  8: one-hot pulse that clears the acknowledged IRR bit.
- `is_status`  out  8: ISR contents.
- `last_serviced`  out  3: lowest-priority level in rotating mode.
- `rotating_priority`  out  1: rotation mode.
- `vector_out`  out  8: {vector_base, level}.
- `vector_valid`  out  1: `vector_out` is valid this cycle.

## Operation
- States:
  - IDLE: waiting for an interrupt request.
  - PEND: `int_out` is high.
  - ACK1: first INTA has been taken.
- IDLE → PEND: `int_flag`=1 in IDLE. `int_out` is registered high in the next cycle.
- PEND + `inta`: latch `priority_id` into `ack_level`, set `is_status[ack_level]`, pulse `irr_clear` one-hot for one cycle, drop `int_out`, go to ACK1.
- PEND + `int_flag` dropping with no `inta`: `int_out` stays high. The 8259 has no INT retraction.
- IDLE + `inta` (spurious): take `ack_level`=7 and go to ACK1. Do not set ISR and do not pulse `irr_clear`.
- ACK1 + `inta`:
  - Next cycle: `vector_out`={vector_base, ack_level}, `vector_valid`=1 for one cycle.
  - Go to IDLE.
  - If AEOI is active, clear `is_status[ack_level]` in the same cycle; if the AEOI-rotate flag is also set, `last_serviced`←`ack_level`.
- OCW2 decode, acted on in the cycle `ocw2_valid`=1:
  - 001 non-specific EOI: clear the highest-priority set ISR bit.
  - 011 specific EOI: clear `is_status[ocw2_level]`.
  - 101 rotate on non-specific EOI: as 001, then `last_serviced`←cleared level and `rotating_priority`←1.
  - 111 rotate on specific EOI: as 011, then `last_serviced`←`ocw2_level` and `rotating_priority`←1.
  - 110 set priority: `last_serviced`←`ocw2_level`, `rotating_priority`←1.
  - 100 set the AEOI-rotate flag; 000 clear it; 010 no-op.
- Highest-priority set ISR bit:
  - `rotating_priority`=0: lowest set index.
  - `rotating_priority`=1: first set bit scanning `last_serviced`+1, +2, … modulo 8.
- Non-specific EOI with an empty ISR: no ISR change and no rotation.
- Reset or `init`: state IDLE, `int_out`=0, `irr_clear`=0, `is_status`=0, `last_serviced`=3'b111, `rotating_priority`=0, AEOI-rotate flag=0, `vector_out`=0, `vector_valid`=0.

## Timing
- Every output is registered.
- `int_flag`→`int_out`: 1 cycle.
- `inta` #1 → `irr_clear` and the ISR bit set: 1 cycle. `int_out` is low in the same cycle.
- `inta` #2 → `vector_valid`: 1 cycle. The AEOI ISR clear lands in that same cycle.
- `ocw2_valid`→ISR, `last_serviced` and `rotating_priority` updates: 1 cycle.
- Same-cycle EOI and INTA:
  - Both take effect.
  - An EOI that targets the bit INTA #1 is setting loses; the bit ends up set.
  - A non-specific EOI selects from the ISR as it was before that cycle.
- `inta` strobes closer than 1 cycle apart are illegal.
- Reset or `init` during ACK1: the sequence aborts and no vector is issued.

## Configuration
- `IN_SERVICE_CTRL_AEOI_EN` defined: AEOI is active when `aeoi_mode`=1, including the rotate-in-AEOI behaviour.
- Not defined: `aeoi_mode` is ignored, and OCW2 codes 100 and 000 become no-ops. The ISR is cleared only by EOI commands.

## Test plan
- Request fully nested: `int_flag`=1 with `priority_id`=3 → `int_out`=1 after 1 cycle. INTA #1 → `irr_clear`=8'h08, `is_status`=8'h08. INTA #2 with `vector_base`=5'h08 → `vector_out`=8'h43.
- Non-specific EOI fully nested: `is_status`=8'h0A, OCW2 001 → `is_status`=8'h08.
- Rotate on non-specific EOI: `is_status`=8'h22, `last_serviced`=3, OCW2 101 → clears bit 5, `is_status`=8'h02, `last_serviced`=5, `rotating_priority`=1.
- Spurious INTA: two INTA strobes with no `int_flag` → `vector_out`={base,3'b111}, `is_status` unchanged, `irr_clear`=0.
- AEOI (macro defined): `aeoi_mode`=1, OCW2 100, level 6 acknowledged → after INTA #2, `is_status`=0 and `last_serviced`=6.
- Reset mid-sequence: `rst_n`=0 after INTA #1 → all outputs at reset values. A later INTA produces no vector until a new request arrives.
